// File: rtl/fei4_cmd_pkg.sv
// Shared definitions for the FE-I4 command transmitter: register map and FSM encoding.
package fei4_cmd_pkg;

    localparam logic [15:0] ADDR_RST      = 16'd0;
    localparam logic [15:0] ADDR_START    = 16'd1;
    localparam logic [15:0] ADDR_SIZE_L   = 16'd2;
    localparam logic [15:0] ADDR_SIZE_H   = 16'd3;
    localparam logic [15:0] ADDR_REPEAT_L = 16'd4;
    localparam logic [15:0] ADDR_REPEAT_H = 16'd5;
    localparam int unsigned MEM_OFFSET    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } tx_state_e;

    // Sequence length clamped to the number of bits the memory can hold.
    function automatic logic [15:0] eff_size(input logic [15:0] size, input int unsigned mem_bytes);
        if (32'(size) > mem_bytes * 8) begin
            return 16'(mem_bytes * 8);
        end
        return size;
    endfunction

endpackage

// File: rtl/cmd_mem_dp.sv
// Single-clock dual-port byte RAM: bus port read/write, serializer port read-only.
// Both read ports are registered (1-cycle latency).
module cmd_mem_dp #(
    parameter int unsigned Depth = 2048,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             a_we_i,
    input  logic             a_re_i,
    input  logic [AddrW-1:0] a_addr_i,
    input  logic [7:0]       a_wdata_i,
    output logic [7:0]       a_rdata_o,
    input  logic [AddrW-1:0] b_addr_i,
    output logic [7:0]       b_rdata_o
);

    logic [7:0] mem_q [Depth];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    // Bus port: the read register only changes on a read strobe so bus data holds.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
    end

    // Serializer port: reads every cycle.
    always_ff @(posedge clk_i) begin
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/fei4_cmd_tx.sv
// FE-I4 command transmitter: bus-loaded bit pattern serialized MSB-first onto CMD_DATA,
// CLK_DIV clocks per bit, with a programmable (or continuous) repeat count.
module fei4_cmd_tx
    import fei4_cmd_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic [15:0] BUS_ADD,
    input  logic [7:0]  BUS_DATA_IN,
    output logic [7:0]  BUS_DATA_OUT,
    input  logic        BUS_WR,
    input  logic        BUS_RD,
    output logic        CMD_DATA,
    output logic        CMD_EN,
    output logic        CMD_READY
);

    localparam int unsigned AddrW   = $clog2(MEM_BYTES);
    localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [16:0] MemEnd  = 17'(MEM_OFFSET + MEM_BYTES);

    tx_state_e     state_q, state_d;
    logic [15:0]   size_q, size_d;          // SIZE register
    logic [15:0]   rep_cfg_q, rep_cfg_d;    // REPEAT register
    logic [15:0]   size_sh_q, size_sh_d;    // values frozen for the active run
    logic [15:0]   rep_sh_q, rep_sh_d;
    logic [15:0]   ptr_q, ptr_d;            // index of the next bit to drive
    logic [DivW-1:0] div_q, div_d;          // clocks left in the current bit period
    logic          done_q, done_d;
    logic          cmd_data_q, cmd_data_d;
    logic          cmd_en_q, cmd_en_d;
    logic [7:0]    rd_reg_q, rd_reg_d;
    logic          rd_mem_q, rd_mem_d;

    logic          rst_req;
    logic          start;
    logic          mem_hit;
    logic [16:0]   add_ext;
    logic [15:0]   size_eff;
    logic [7:0]    bus_rdata;
    logic [7:0]    ser_rdata;

    assign add_ext  = {1'b0, BUS_ADD};
    assign mem_hit  = (add_ext >= 17'(MEM_OFFSET)) && (add_ext < MemEnd);
    assign rst_req  = BUS_RST || (BUS_WR && (BUS_ADD == ADDR_RST));
    assign start    = BUS_WR && (BUS_ADD == ADDR_START);
    assign size_eff = eff_size(size_q, MEM_BYTES);

    cmd_mem_dp #(
        .Depth (MEM_BYTES),
        .AddrW (AddrW)
    ) u_mem (
        .clk_i     (BUS_CLK),
        .a_we_i    (BUS_WR && mem_hit),
        .a_re_i    (BUS_RD && mem_hit),
        .a_addr_i  (AddrW'(BUS_ADD - 16'(MEM_OFFSET))),
        .a_wdata_i (BUS_DATA_IN),
        .a_rdata_o (bus_rdata),
        // Address the byte of the bit loaded next, so it is ready in time: no gaps.
        .b_addr_i  (ptr_d[AddrW+2:3]),
        .b_rdata_o (ser_rdata)
    );

    // Next-state: register writes, bus read decode, and the serializer FSM.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        rep_cfg_d  = rep_cfg_q;
        size_sh_d  = size_sh_q;
        rep_sh_d   = rep_sh_q;
        ptr_d      = ptr_q;
        div_d      = div_q;
        done_d     = done_q;
        cmd_data_d = cmd_data_q;
        cmd_en_d   = cmd_en_q;
        rd_reg_d   = rd_reg_q;
        rd_mem_d   = rd_mem_q;

        if (BUS_WR) begin
            case (BUS_ADD)
                ADDR_SIZE_L:   size_d[7:0]     = BUS_DATA_IN;
                ADDR_SIZE_H:   size_d[15:8]    = BUS_DATA_IN;
                ADDR_REPEAT_L: rep_cfg_d[7:0]  = BUS_DATA_IN;
                ADDR_REPEAT_H: rep_cfg_d[15:8] = BUS_DATA_IN;
                default: ;
            endcase
        end

        if (BUS_RD) begin
            rd_mem_d = mem_hit;
            case (BUS_ADD)
                ADDR_START:    rd_reg_d = {6'b0, state_q != StIdle, done_q};
                ADDR_SIZE_L:   rd_reg_d = size_q[7:0];
                ADDR_SIZE_H:   rd_reg_d = size_q[15:8];
                ADDR_REPEAT_L: rd_reg_d = rep_cfg_q[7:0];
                ADDR_REPEAT_H: rd_reg_d = rep_cfg_q[15:8];
                default:       rd_reg_d = 8'h00;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (size_eff == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        size_sh_d = size_eff;
                        rep_sh_d  = rep_cfg_q;
                        done_d    = 1'b0;
                        ptr_d     = 16'd0;
                        div_d     = '0;
                        state_d   = StLoad;
                    end
                end
            end
            // Byte 0 is addressed here; its data is valid on entry to StSend.
            StLoad: state_d = StSend;
            StSend: begin
                if (div_q != '0) begin
                    div_d = div_q - DivW'(1);
                end else if (ptr_q == size_sh_q) begin
                    // Last bit period has elapsed.
                    cmd_en_d   = 1'b0;
                    cmd_data_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else begin
                    cmd_en_d   = 1'b1;
                    cmd_data_d = ser_rdata[3'd7 - ptr_q[2:0]];
                    div_d      = DivLast;
                    // Wrap straight to bit 0 while repeats remain; REPEAT==0 runs forever.
                    if ((ptr_q == size_sh_q - 16'd1) && (rep_sh_q != 16'd1)) begin
                        ptr_d = 16'd0;
                        if (rep_sh_q != 16'd0) begin
                            rep_sh_d = rep_sh_q - 16'd1;
                        end
                    end else begin
                        ptr_d = ptr_q + 16'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers; bus or soft reset wins over everything, memory is left intact.
    always_ff @(posedge BUS_CLK) begin
        if (rst_req) begin
            state_q    <= StIdle;
            size_q     <= 16'd0;
            rep_cfg_q  <= 16'd1;
            size_sh_q  <= 16'd0;
            rep_sh_q   <= 16'd1;
            ptr_q      <= 16'd0;
            div_q      <= '0;
            done_q     <= 1'b0;
            cmd_data_q <= 1'b0;
            cmd_en_q   <= 1'b0;
            rd_reg_q   <= 8'h00;
            rd_mem_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            rep_cfg_q  <= rep_cfg_d;
            size_sh_q  <= size_sh_d;
            rep_sh_q   <= rep_sh_d;
            ptr_q      <= ptr_d;
            div_q      <= div_d;
            done_q     <= done_d;
            cmd_data_q <= cmd_data_d;
            cmd_en_q   <= cmd_en_d;
            rd_reg_q   <= rd_reg_d;
            rd_mem_q   <= rd_mem_d;
        end
    end

    assign BUS_DATA_OUT = rd_mem_q ? bus_rdata : rd_reg_q;
    assign CMD_DATA     = cmd_data_q;
    assign CMD_EN       = cmd_en_q;
    assign CMD_READY    = (state_q == StIdle);

endmodule
